// File: rtl/pixel_stream_packer.sv
// Pixel sink: raster-tags r/g/b pixels (SOF/EOL/EOF), buffers them in a FIFO and emits AXI4-Stream video.
// Optional FRAME_CNT_EN adds a 16-bit completed-frame counter output.
module pixel_stream_packer #(
  parameter int FIFO_DEPTH = 16,
  parameter int DIM_W      = 13
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic [DIM_W-1:0]              image_width,
  input  logic [DIM_W-1:0]              image_height,
  input  logic                          pix_valid,
  output logic                          pix_ready,
  input  logic [7:0]                    pix_r,
  input  logic [7:0]                    pix_g,
  input  logic [7:0]                    pix_b,
  output logic [31:0]                   m_tdata,
  output logic                          m_tvalid,
  input  logic                          m_tready,
  output logic                          m_tuser,
  output logic                          m_tlast,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
`ifdef FRAME_CNT_EN
  output logic [15:0]                   frame_count,
`endif
  output logic                          frame_done
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t             state;
  logic [DIM_W-1:0]   x, y, wlat, hlat;
  logic [DIM_W-1:0]   w_in, h_in, cur_w, cur_h, cur_x, cur_y;
  logic               sof, eol, eof;

  logic [26:0]        mem [FIFO_DEPTH];
  logic [AW-1:0]      wr_ptr, rd_ptr;
  logic [LW-1:0]      level, level_nxt;
  logic [26:0]        head;
  logic               push, pop;

  assign push     = pix_valid & pix_ready;
  assign pop      = m_tvalid & m_tready;
  assign m_tvalid = (level != '0);
  assign head     = mem[rd_ptr];

  // Head fields are gated so the stream reads all-zero whenever the FIFO is empty (incl. after reset).
  assign m_tdata    = m_tvalid ? {8'h00, head[23:0]} : '0;
  assign m_tlast    = m_tvalid & head[24];
  assign m_tuser    = m_tvalid & head[25];
  assign fifo_level = level;

  always_comb begin
    w_in  = (image_width  == '0) ? DIM_W'(1) : image_width;
    h_in  = (image_height == '0) ? DIM_W'(1) : image_height;
    sof   = (state == IDLE);
    cur_w = sof ? w_in : wlat;
    cur_h = sof ? h_in : hlat;
    cur_x = sof ? '0 : x;
    cur_y = sof ? '0 : y;
    eol   = (cur_x == cur_w - DIM_W'(1));
    eof   = eol && (cur_y == cur_h - DIM_W'(1));
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= IDLE;
      x     <= '0;
      y     <= '0;
      wlat  <= DIM_W'(1);
      hlat  <= DIM_W'(1);
    end else if (push) begin
      if (state == IDLE) begin
        wlat <= w_in;
        hlat <= h_in;
      end
      if (eof) begin
        state <= IDLE;
        x     <= '0;
        y     <= '0;
      end else if (eol) begin
        state <= ACTIVE;
        x     <= '0;
        y     <= cur_y + DIM_W'(1);
      end else begin
        state <= ACTIVE;
        x     <= cur_x + DIM_W'(1);
        y     <= cur_y;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {eof, sof, eol, pix_r, pix_g, pix_b};
  end

  always_comb begin
    level_nxt = level + LW'(push) - LW'(pop);
  end

  // pix_ready is computed from the next occupancy so it is a plain flop with no path from m_tready.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      level      <= '0;
      pix_ready  <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      level      <= level_nxt;
      pix_ready  <= (level_nxt < LW'(FIFO_DEPTH));
      frame_done <= pop & head[26];
    end
  end

`ifdef FRAME_CNT_EN
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      frame_count <= '0;
    end else if (pop && head[26]) begin
      frame_count <= frame_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pixel_stream_packer.sv
// Directed self-checking bench for pixel_stream_packer (also checks frame_count when FRAME_CNT_EN is defined).
module tb_pixel_stream_packer;

  localparam int DEPTH = 16;
  localparam int DW    = 13;
  localparam int LW    = $clog2(DEPTH) + 1;
  localparam int TMO   = 300;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [DW-1:0] image_width, image_height;
  logic          pix_valid, pix_ready;
  logic [7:0]    pix_r, pix_g, pix_b;
  logic [31:0]   m_tdata;
  logic          m_tvalid, m_tready, m_tuser, m_tlast, frame_done;
  logic [LW-1:0] fifo_level;
`ifdef FRAME_CNT_EN
  logic [15:0]   frame_count;
`endif

  logic tready_fix = 1'b0;
  logic rand_mode  = 1'b0;
  logic rnd_rdy    = 1'b0;
  assign m_tready = rand_mode ? rnd_rdy : tready_fix;

  pixel_stream_packer #(.FIFO_DEPTH(DEPTH), .DIM_W(DW)) dut (
    .clk(clk), .reset_n(reset_n),
    .image_width(image_width), .image_height(image_height),
    .pix_valid(pix_valid), .pix_ready(pix_ready),
    .pix_r(pix_r), .pix_g(pix_g), .pix_b(pix_b),
    .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tready(m_tready),
    .m_tuser(m_tuser), .m_tlast(m_tlast),
    .fifo_level(fifo_level),
`ifdef FRAME_CNT_EN
    .frame_count(frame_count),
`endif
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) begin
    cyc     <= cyc + 1;
    rnd_rdy <= 1'($urandom_range(0, 1));
  end

  logic [31:0] bdata [256];
  logic        buser [256];
  logic        blast [256];
  int          bcyc  [256];
  int          fdcyc [64];
  logic [15:0] fcat  [64];
  int          nbeats = 0;
  int          nfd    = 0;

  always @(negedge clk) begin
    if (m_tvalid && m_tready && nbeats < 256) begin
      bdata[nbeats] = m_tdata;
      buser[nbeats] = m_tuser;
      blast[nbeats] = m_tlast;
      bcyc[nbeats]  = cyc;
      nbeats++;
    end
    if (frame_done && nfd < 64) begin
      fdcyc[nfd] = cyc;
`ifdef FRAME_CNT_EN
      fcat[nfd] = frame_count;
`else
      fcat[nfd] = 16'h0;
`endif
      nfd++;
    end
  end

  int passed = 0;
  int total  = 0;
  int failed = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_pix(input logic [7:0] id);
    return {8'h00, id, id ^ 8'h5A, ~id};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Leaves pix_valid high so consecutive calls stream back-to-back.
  task automatic push(input logic [7:0] id);
    int t;
    pix_r = id;
    pix_g = id ^ 8'h5A;
    pix_b = ~id;
    pix_valid = 1'b1;
    t = 0;
    while (!pix_ready && t < TMO) begin
      tick();
      t++;
    end
    if (t >= TMO) chk("push_timeout", 32'(pix_ready), 32'd1);
    tick();
  endtask

  task automatic push_n(input int n, input logic [7:0] id0);
    for (int i = 0; i < n; i++) push(id0 + 8'(i));
    pix_valid = 1'b0;
  endtask

  task automatic wait_beats(input int target);
    int t;
    t = 0;
    while (nbeats < target && t < TMO) begin
      tick();
      t++;
    end
    chk("beat_count", 32'(nbeats), 32'(target));
    tick();
    tick();
  endtask

  task automatic chk_frame(input int base, input int n, input logic [7:0] id0, input int w, input int h);
    for (int i = 0; i < n; i++) begin
      logic [7:0] id;
      id = id0 + 8'(i);
      chk("beat_data",  bdata[base+i], exp_pix(id));
      chk("beat_tuser", 32'(buser[base+i]), 32'((i % (w*h)) == 0));
      chk("beat_tlast", 32'(blast[base+i]), 32'((i % w) == (w-1)));
    end
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
  endtask

  int base, fd0, acc;
  logic rdy_now;

  initial begin
    reset_n = 1'b0;
    pix_valid = 1'b0;
    pix_r = '0; pix_g = '0; pix_b = '0;
    image_width = 13'd4;
    image_height = 13'd2;
    tready_fix = 1'b1;
    tick();
    tick();
    chk("rst_pix_ready",  32'(pix_ready), 32'd0);
    chk("rst_tvalid",     32'(m_tvalid), 32'd0);
    chk("rst_tdata",      m_tdata, 32'd0);
    chk("rst_tuser",      32'(m_tuser), 32'd0);
    chk("rst_tlast",      32'(m_tlast), 32'd0);
    chk("rst_level",      32'(fifo_level), 32'd0);
    chk("rst_frame_done", 32'(frame_done), 32'd0);
`ifdef FRAME_CNT_EN
    chk("rst_frame_count", 32'(frame_count), 32'd0);
`endif
    reset_n = 1'b1;
    tick();
    chk("ready_after_rst", 32'(pix_ready), 32'd1);

    // 4x2 frame back-to-back
    base = nbeats; fd0 = nfd;
    push_n(8, 8'h10);
    wait_beats(base + 8);
    chk_frame(base, 8, 8'h10, 4, 2);
    chk("t1_fd_count", 32'(nfd - fd0), 32'd1);
    chk("t1_fd_cycle", 32'(fdcyc[fd0]), 32'(bcyc[base+7] + 1));

    // fill to full with downstream stalled, then drain
    tready_fix = 1'b0;
    base = nbeats; fd0 = nfd;
    acc = 0;
    pix_valid = 1'b1;
    for (int c = 0; c < 30; c++) begin
      pix_r = 8'h40 + 8'(acc);
      pix_g = pix_r ^ 8'h5A;
      pix_b = ~pix_r;
      rdy_now = pix_ready;
      tick();
      if (rdy_now) acc++;
    end
    pix_valid = 1'b0;
    chk("t2_accepted",   32'(acc), 32'd16);
    chk("t2_level_full", 32'(fifo_level), 32'd16);
    chk("t2_ready_full", 32'(pix_ready), 32'd0);
    chk("t2_tvalid",     32'(m_tvalid), 32'd1);
    tready_fix = 1'b1;
    tick();
    chk("t2_ready_after_pop", 32'(pix_ready), 32'd1);
    chk("t2_level_after_pop", 32'(fifo_level), 32'd15);
    wait_beats(base + 16);
    chk_frame(base, 16, 8'h40, 4, 2);
    chk("t2_level_empty", 32'(fifo_level), 32'd0);
    chk("t2_fd_count",    32'(nfd - fd0), 32'd2);

    // zero dimensions behave as 1x1
    image_width = 13'd0;
    image_height = 13'd0;
    base = nbeats; fd0 = nfd;
    push_n(2, 8'h80);
    wait_beats(base + 2);
    chk_frame(base, 2, 8'h80, 1, 1);
    chk("t3_fd_count", 32'(nfd - fd0), 32'd2);

    // reset mid-frame drops buffered pixels
    image_width = 13'd4;
    image_height = 13'd2;
    tready_fix = 1'b0;
    push_n(3, 8'hF0);
    tick();
    chk("t4_level_pre", 32'(fifo_level), 32'd3);
    do_reset();
    chk("t4_tvalid_post", 32'(m_tvalid), 32'd0);
    chk("t4_level_post",  32'(fifo_level), 32'd0);
    tready_fix = 1'b1;
    base = nbeats; fd0 = nfd;
    push_n(8, 8'hA0);
    wait_beats(base + 8);
    chk_frame(base, 8, 8'hA0, 4, 2);
    chk("t4_fd_count", 32'(nfd - fd0), 32'd1);

    // width change mid-frame takes effect at next SOF
    base = nbeats;
    push(8'hC0);
    image_width = 13'd2;
    for (int i = 1; i < 12; i++) push(8'hC0 + 8'(i));
    pix_valid = 1'b0;
    wait_beats(base + 12);
    chk_frame(base, 8, 8'hC0, 4, 2);
    chk_frame(base + 8, 4, 8'hC8, 2, 2);

    // three 2x2 frames under random downstream stalls
    do_reset();
`ifdef FRAME_CNT_EN
    chk("t6_fc_reset", 32'(frame_count), 32'd0);
`endif
    rand_mode = 1'b1;
    base = nbeats; fd0 = nfd;
    push_n(12, 8'h20);
    wait_beats(base + 12);
    rand_mode = 1'b0;
    tick();
    chk_frame(base, 12, 8'h20, 2, 2);
    chk("t6_fd_count", 32'(nfd - fd0), 32'd3);
`ifdef FRAME_CNT_EN
    for (int k = 0; k < 3; k++) chk("t6_frame_count", 32'(fcat[fd0+k]), 32'(k + 1));
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
